// File: rtl/dtree_frame_sequencer.sv
// Serial front end for a combinational decision-tree classifier: assembles a
// feature frame onto a held parallel bus, waits for the tree to settle, registers the class.
module dtree_frame_sequencer #(
   parameter int N_FEAT     = 36,
   parameter int FEAT_W     = 8,
   parameter int CLASS_W    = 5,
   parameter int SETTLE_CYC = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     in_valid,
   input  logic [FEAT_W-1:0]        in_data,
   input  logic                     in_last,
   output logic                     in_ready,
   output logic [N_FEAT*FEAT_W-1:0] feat_bus,
   input  logic [CLASS_W-1:0]       tree_class,
   output logic                     out_valid,
   output logic [CLASS_W-1:0]       out_class,
   input  logic                     out_ready,
   output logic                     frame_err,
   output logic                     busy
);

   localparam int IDX_W  = $clog2(N_FEAT);
   localparam int SCNT_W = $clog2(SETTLE_CYC + 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_FEAT - 1);
   localparam logic [SCNT_W-1:0] SCNT_INIT = SCNT_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    idx, idx_nxt;
   logic [SCNT_W-1:0]   scnt, scnt_nxt;
   logic                err_nxt;
   logic                wr_en;
   logic                cap_en;
   logic [FEAT_W-1:0]   feat_q [N_FEAT];

   // Handshake outputs are pure state decodes, so nothing combinational leaks
   // from in_valid or out_ready to the outputs.
   assign in_ready  = (state == LOAD);
   assign out_valid = (state == HOLD);
   assign busy      = (state == SETTLE) || (state == HOLD);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_nxt = state;
      idx_nxt   = idx;
      scnt_nxt  = scnt;
      err_nxt   = 1'b0;
      wr_en     = 1'b0;
      cap_en    = 1'b0;

      if (clr) begin
         state_nxt = LOAD;
         idx_nxt   = '0;
         scnt_nxt  = SCNT_INIT;
      end else begin
         case (state)
            LOAD: begin
               if (in_valid) begin
                  if (in_last != (idx == IDX_LAST)) begin
                     // in_last disagrees with the slot position: drop the frame.
                     err_nxt = 1'b1;
                     idx_nxt = '0;
                  end else if (in_last) begin
                     wr_en     = 1'b1;
                     idx_nxt   = '0;
                     state_nxt = SETTLE;
                  end else begin
                     wr_en   = 1'b1;
                     idx_nxt = idx + IDX_W'(1);
                  end
               end
            end
            SETTLE: begin
               if (scnt == '0) begin
                  cap_en    = 1'b1;
                  scnt_nxt  = SCNT_INIT;
                  state_nxt = HOLD;
               end else begin
                  scnt_nxt = scnt - SCNT_W'(1);
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_nxt = LOAD;
               end
            end
            default: begin
               state_nxt = LOAD;
               idx_nxt   = '0;
               scnt_nxt  = SCNT_INIT;
            end
         endcase
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD;
         idx       <= '0;
         scnt      <= SCNT_INIT;
         frame_err <= 1'b0;
         out_class <= '0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         scnt      <= scnt_nxt;
         frame_err <= err_nxt;
         if (cap_en) begin
            out_class <= tree_class;
         end
      end
   end

   // NOTE: the feature slots are reset even though they form a register array,
   // because they drive the tree directly and must come up at a known zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_FEAT; k++) begin
            feat_q[k] <= '0;
         end
      end else if (wr_en) begin
         feat_q[idx] <= in_data;
      end
   end

   for (genvar k = 0; k < N_FEAT; k++) begin : g_flat
      assign feat_bus[k*FEAT_W +: FEAT_W] = feat_q[k];
   end

endmodule

// File: tb/tb_dtree_frame_sequencer.sv
// Directed self-checking bench for dtree_frame_sequencer, including a
// SETTLE_CYC sweep on two extra instances fed from a separate valid line.
module tb_dtree_frame_sequencer;

   localparam int N  = 36;
   localparam int W  = 8;
   localparam int CW = 5;
   localparam int BW = N * W;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b1;
   logic          clr        = 1'b0;
   logic          in_valid   = 1'b0;
   logic          sw_valid   = 1'b0;
   logic [W-1:0]  in_data    = '0;
   logic          in_last    = 1'b0;
   logic [CW-1:0] tree_class = '0;
   logic          out_ready  = 1'b0;
   logic          route_sw   = 1'b0;

   logic          in_ready, out_valid, frame_err, busy;
   logic [BW-1:0] feat_bus;
   logic [CW-1:0] out_class;
   logic          in_ready1, out_valid1, frame_err1, busy1;
   logic [BW-1:0] feat_bus1;
   logic [CW-1:0] out_class1;
   logic          in_ready4, out_valid4, frame_err4, busy4;
   logic [BW-1:0] feat_bus4;
   logic [CW-1:0] out_class4;

   int            total = 0;
   int            bad   = 0;
   logic [BW-1:0] exp_bus = '0;
   logic [BW-1:0] exp_sw  = '0;
   logic [CW-1:0] cls;
   int            gaps;

   always #5 clk = ~clk;

   dtree_frame_sequencer #(.N_FEAT(N), .FEAT_W(W), .CLASS_W(CW), .SETTLE_CYC(2)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .feat_bus(feat_bus), .tree_class(tree_class),
      .out_valid(out_valid), .out_class(out_class), .out_ready(out_ready),
      .frame_err(frame_err), .busy(busy));

   dtree_frame_sequencer #(.N_FEAT(N), .FEAT_W(W), .CLASS_W(CW), .SETTLE_CYC(1)) dut_s1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(sw_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready1), .feat_bus(feat_bus1), .tree_class(tree_class),
      .out_valid(out_valid1), .out_class(out_class1), .out_ready(out_ready),
      .frame_err(frame_err1), .busy(busy1));

   dtree_frame_sequencer #(.N_FEAT(N), .FEAT_W(W), .CLASS_W(CW), .SETTLE_CYC(4)) dut_s4 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(sw_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready4), .feat_bus(feat_bus4), .tree_class(tree_class),
      .out_valid(out_valid4), .out_class(out_class4), .out_ready(out_ready),
      .frame_err(frame_err4), .busy(busy4));

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [W-1:0] d, input logic l);
      if (route_sw) sw_valid = 1'b1;
      else          in_valid = 1'b1;
      in_data = d;
      in_last = l;
      tick();
      in_valid = 1'b0;
      sw_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Beat k carries base+k; a beat whose in_last disagrees with its slot is not stored.
   task automatic send_frame(input logic [W-1:0] base, input int n, input int last_pos);
      for (int k = 0; k < n; k++) begin
         logic l;
         logic err;
         l   = (k == last_pos);
         err = (l && k < N - 1) || (!l && k == N - 1);
         beat(base + W'(k), l);
         if (!err) begin
            if (route_sw) exp_sw[k*W +: W]  = base + W'(k);
            else          exp_bus[k*W +: W] = base + W'(k);
         end
      end
   endtask

   // Called right after the final beat's edge t: result appears at t+2.
   task automatic expect_result(input string tag, input logic [CW-1:0] c);
      check_bit({tag, "_busy"}, busy, 1'b1);
      check_bit({tag, "_valid_t0"}, out_valid, 1'b0);
      tick();
      check_bit({tag, "_valid_t1"}, out_valid, 1'b0);
      tick();
      check_bit({tag, "_valid_t2"}, out_valid, 1'b1);
      check({tag, "_class"}, BW'(out_class), BW'(c));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_frame_err", frame_err, 1'b0);
      check("rst_feat_bus", feat_bus, '0);
      check("rst_out_class", BW'(out_class), '0);
      rst_n = 1'b1;
      tick();
      check_bit("rst_in_ready", in_ready, 1'b1);

      // Basic frame
      tree_class = 5'd14;
      out_ready  = 1'b1;
      send_frame(8'd1, N, N - 1);
      check("basic_slot35", BW'(feat_bus[35*W +: W]), BW'(8'd36));
      check("basic_bus", feat_bus, exp_bus);
      check_bit("basic_in_ready_settle", in_ready, 1'b0);
      check_bit("basic_no_err", frame_err, 1'b0);
      expect_result("basic", 5'd14);
      tick();
      check_bit("basic_valid_one_cycle", out_valid, 1'b0);
      check_bit("basic_in_ready_back", in_ready, 1'b1);

      // Backpressure with an extra beat presented during HOLD
      out_ready = 1'b0;
      send_frame(8'hA0, N, N - 1);
      expect_result("bp", 5'd14);
      tree_class = 5'd9;
      in_valid   = 1'b1;
      in_data    = 8'hEE;
      for (int c = 0; c < 10; c++) begin
         tick();
         check_bit("bp_hold_valid", out_valid, 1'b1);
         check("bp_hold_class", BW'(out_class), BW'(5'd14));
         check_bit("bp_in_ready", in_ready, 1'b0);
         check("bp_bus", feat_bus, exp_bus);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check_bit("bp_release_valid", out_valid, 1'b0);
      check_bit("bp_release_in_ready", in_ready, 1'b1);
      check("bp_extra_not_taken", feat_bus, exp_bus);

      // Early in_last on beat 10, then a clean frame
      tree_class = 5'd3;
      send_frame(8'h50, 11, 10);
      check_bit("early_err", frame_err, 1'b1);
      check_bit("early_busy", busy, 1'b0);
      check_bit("early_in_ready", in_ready, 1'b1);
      check("early_bus", feat_bus, exp_bus);
      tick();
      check_bit("early_err_pulse", frame_err, 1'b0);
      repeat (3) tick();
      check_bit("early_no_valid", out_valid, 1'b0);
      send_frame(8'h30, N, N - 1);
      check("early_clean_bus", feat_bus, exp_bus);
      expect_result("early_clean", 5'd3);
      tick();

      // Missing in_last on beat 35
      send_frame(8'h80, N, -1);
      check_bit("miss_err", frame_err, 1'b1);
      check_bit("miss_busy", busy, 1'b0);
      check("miss_bus", feat_bus, exp_bus);
      tick();
      check_bit("miss_err_pulse", frame_err, 1'b0);
      check_bit("miss_busy_after", busy, 1'b0);
      check_bit("miss_no_valid", out_valid, 1'b0);

      // Input bubbles with a tree stub that changes every cycle
      out_ready = 1'b0;
      for (int k = 0; k < N; k++) begin
         gaps = $urandom_range(0, 2);
         for (int g = 0; g < gaps; g++) begin
            in_data    = W'($urandom);
            in_last    = 1'($urandom);
            tree_class = CW'($urandom);
            tick();
            check("bub_idle_bus", feat_bus, exp_bus);
         end
         tree_class = CW'($urandom);
         beat(W'(k * 7 + 3), k == N - 1);
         exp_bus[k*W +: W] = W'(k * 7 + 3);
         check("bub_beat_bus", feat_bus, exp_bus);
      end
      check_bit("bub_busy_t0", busy, 1'b1);
      tree_class = CW'($urandom);
      tick();
      check("bub_settle_bus", feat_bus, exp_bus);
      check_bit("bub_settle_valid", out_valid, 1'b0);
      cls        = CW'($urandom);
      tree_class = cls;
      tick();
      check_bit("bub_valid", out_valid, 1'b1);
      check("bub_class", BW'(out_class), BW'(cls));
      for (int c = 0; c < 4; c++) begin
         tree_class = CW'($urandom);
         tick();
         check("bub_hold_bus", feat_bus, exp_bus);
         check("bub_hold_class", BW'(out_class), BW'(cls));
         check_bit("bub_hold_busy", busy, 1'b1);
      end
      out_ready = 1'b1;
      tick();
      check_bit("bub_release", out_valid, 1'b0);

      // Asynchronous reset at beat 20
      tree_class = 5'd21;
      send_frame(8'h60, 20, -1);
      in_valid = 1'b1;
      in_data  = 8'h74;
      #2 rst_n = 1'b0;
      #1;
      check("arst_bus", feat_bus, '0);
      check("arst_class", BW'(out_class), '0);
      check_bit("arst_busy", busy, 1'b0);
      check_bit("arst_valid", out_valid, 1'b0);
      check_bit("arst_err", frame_err, 1'b0);
      exp_bus  = '0;
      in_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check_bit("arst_in_ready", in_ready, 1'b1);
      send_frame(8'h20, N, N - 1);
      check("arst_next_bus", feat_bus, exp_bus);
      expect_result("arst_next", 5'd21);
      tick();

      // clr mid-frame drops the in-flight beat and restarts at slot 0
      tree_class = 5'd6;
      send_frame(8'h40, 5, -1);
      in_valid = 1'b1;
      in_data  = 8'h99;
      clr      = 1'b1;
      tick();
      clr      = 1'b0;
      in_valid = 1'b0;
      check("clr_mid_bus", feat_bus, exp_bus);
      check_bit("clr_mid_err", frame_err, 1'b0);
      send_frame(8'h48, N, N - 1);
      expect_result("clr_mid_next", 5'd6);
      tick();

      // clr during HOLD
      out_ready  = 1'b0;
      tree_class = 5'd11;
      send_frame(8'hC0, N, N - 1);
      expect_result("clr_hold", 5'd11);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_bit("clr_hold_valid", out_valid, 1'b0);
      check_bit("clr_hold_busy", busy, 1'b0);
      check_bit("clr_hold_in_ready", in_ready, 1'b1);
      check("clr_hold_class_kept", BW'(out_class), BW'(5'd11));
      check("clr_hold_bus_kept", feat_bus, exp_bus);

      // SETTLE_CYC sweep: 1 and 4
      route_sw   = 1'b1;
      tree_class = 5'd17;
      send_frame(8'h10, N, N - 1);
      check_bit("sw_main_idle", busy, 1'b0);
      check_bit("sw1_busy", busy1, 1'b1);
      check_bit("sw4_busy", busy4, 1'b1);
      check_bit("sw1_valid_t0", out_valid1, 1'b0);
      check("sw1_bus", feat_bus1, exp_sw);
      check("sw4_bus", feat_bus4, exp_sw);
      tick();
      check_bit("sw1_valid_t1", out_valid1, 1'b1);
      check("sw1_class", BW'(out_class1), BW'(5'd17));
      check_bit("sw4_valid_t1", out_valid4, 1'b0);
      repeat (2) tick();
      check_bit("sw4_valid_t3", out_valid4, 1'b0);
      tick();
      check_bit("sw4_valid_t4", out_valid4, 1'b1);
      check("sw4_class", BW'(out_class4), BW'(5'd17));
      check_bit("sw1_still_valid", out_valid1, 1'b1);
      out_ready = 1'b1;
      tick();
      check_bit("sw1_release", out_valid1, 1'b0);
      check_bit("sw4_release", out_valid4, 1'b0);
      check_bit("sw1_in_ready", in_ready1, 1'b1);
      check_bit("sw4_in_ready", in_ready4, 1'b1);
      check_bit("sw1_no_err", frame_err1, 1'b0);
      check_bit("sw4_no_err", frame_err4, 1'b0);
      route_sw = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dtree_frame_sequencer.md
# dtree_frame_sequencer

Sequencer that sits in front of a combinational decision-tree classifier with 36 × 8-bit feature inputs and a 5-bit class output. It takes features serially over a byte-wide valid/ready stream and assembles them into a held parallel feature bus that drives the tree. It waits a programmable number of cycles for the slow tree logic to settle, then captures the class into a valid/ready result register. The tree therefore only ever sees a stable, complete feature vector, and the host interface shrinks from 288 wires to 8.

## Interface

Parameters:

- N_FEAT, 36, number of features per frame; must be ≥ 2
- FEAT_W, 8, bits per feature
- CLASS_W, 5, width of the tree output
- SETTLE_CYC, 2, cycles the feature bus is held stable before the class is sampled; must be ≥ 1

Ports:

- clk, input, 1, single clock; all state changes on the rising edge
- rst_n, input, 1, asynchronous active-low reset
- clr, input, 1, synchronous abort; returns to LOAD with idx = 0
- in_valid, input, 1, feature beat valid
- in_data, input, FEAT_W, feature value
- in_last, input, 1, marks the final beat of a frame
- in_ready, output, 1, beat accepted when in_valid & in_ready
- feat_bus, output, N_FEAT*FEAT_W, to tree; feature k at [k*FEAT_W +: FEAT_W]
- tree_class, input, CLASS_W, combinational class from the tree
- out_valid, output, 1, result valid
- out_class, output, CLASS_W, registered class
- out_ready, input, 1, result consumed when out_valid & out_ready
- frame_err, output, 1, one-cycle pulse on framing error
- busy, output, 1, high in SETTLE or HOLD

## Operation

- **Feature order.** Beat k of a frame is feature k, in tree port order (X0 first).
- **States.**
  - LOAD: in_ready = 1. Each accepted beat writes feat_bus slot idx and increments idx.
  - SETTLE: in_ready = 0. Counter scnt counts down from SETTLE_CYC-1.
  - HOLD: out_valid = 1, in_ready = 0.
- **Transitions.**
  - LOAD → SETTLE on an accepted beat with idx == N_FEAT-1 and in_last = 1.
  - SETTLE → HOLD when scnt == 0. On that edge tree_class is loaded into out_class.
  - HOLD → LOAD on out_valid & out_ready. idx returns to 0.
- **Framing errors.** Each causes a one-cycle frame_err pulse, sets idx = 0 and keeps the state at LOAD.
  - Accepted beat with in_last = 1 and idx < N_FEAT-1.
  - Accepted beat with in_last = 0 and idx == N_FEAT-1.
  - The erroring beat's data is not written. Earlier slots keep their stale values, which are overwritten by the next frame.
- **Stability.** feat_bus changes only on accepted LOAD beats. It is constant throughout SETTLE and HOLD.
- **clr.** Forces LOAD, idx = 0, scnt = SETTLE_CYC-1, out_valid = 0. It does not clear feat_bus or out_class. clr has priority over every other event in the same cycle, including an in-flight handshake, which is dropped.
- **Widths.** idx uses $clog2(N_FEAT) bits; scnt uses $clog2(SETTLE_CYC+1) bits. Neither counter wraps: idx never exceeds N_FEAT-1.

## Timing

- **Reset values** (rst_n low, asynchronous):
  - state = LOAD, idx = 0, scnt = SETTLE_CYC-1
  - feat_bus = 0, out_class = 0
  - out_valid = 0, frame_err = 0, busy = 0, in_ready = 1 (after reset release)
- **Throughput.** One feature per cycle in LOAD, so a full frame takes N_FEAT cycles.
- **Latency.** If the final beat is accepted at edge t, then busy = 1 from t, out_class is captured at edge t+SETTLE_CYC, and out_valid = 1 from t+SETTLE_CYC.
- **Result handshake.** out_valid stays high with out_class stable until a handshake completes. If out_ready is already high, out_valid lasts exactly one cycle. in_ready rises in the cycle after the result handshake.
- **Beat during SETTLE/HOLD.** in_ready = 0, so the beat is ignored and must be held by the source. No error is flagged.
- **Reset mid-frame.** Asynchronous return to the reset values. A partial frame is discarded.
- **Outputs.** All outputs are registered or decoded from state only; none depend combinationally on in_valid or out_ready.

## Test plan

- **Basic frame.** Reset, then send beats k = 0..35 with value k+1 and in_last on beat 35; tree stub returns 5'd14; out_ready = 1. Expect feat_bus slot 35 = 36, out_valid high 2 cycles after the last beat for exactly 1 cycle, and out_class = 14.
- **Backpressure.** Same frame with out_ready = 0 for 10 cycles. Expect out_valid held and out_class = 14 stable, in_ready = 0, and an extra beat presented meanwhile not accepted. After out_ready = 1, in_ready = 1 on the next cycle.
- **Early in_last.** in_last on beat 10. Expect a frame_err pulse, idx = 0, and no out_valid. A following clean frame returning class 3 produces out_class = 3.
- **Missing in_last.** Beat 35 with in_last = 0. Expect frame_err, no SETTLE, and busy = 0.
- **Input bubbles.** Toggle in_valid randomly over a frame. Expect feat_bus to match the beat order exactly and to stay unchanged while busy = 1 (checked every cycle against a stub that changes tree_class).
- **Abort.** Assert rst_n low at beat 20 and, separately, clr during HOLD. Expect the reset values for rst_n and out_valid = 0 with idx = 0 for clr. The next full frame completes normally with SETTLE_CYC = 1 and 4 (parameter sweep).
